traffic_light_fsm: RTL and testbench

Phase controller for the two-way (NS/EW) intersection in the traffic-light controller. It consumes the seconds count from the shared `timer` stage and restarts that timer on every phase change. It sequences green/yellow/all-red phases, inserts a pedestrian walk phase on request, and overrides everything with all-red while an emergency is signalled. `clk` is the 1 Hz tick domain, so one cycle is one second.

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/traffic_light_fsm.sv | 88 ++++++++
 tb/tb_traffic_light_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the NS/EW traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    PED_WALK,
    EMERG
  } phase_t;

  typedef enum logic {
    DIR_NS,
    DIR_EW
  } dir_t;

  localparam int DEF_WIDTH    = 6;
  localparam int DEF_T_GREEN  = 20;
  localparam int DEF_T_YELLOW = 3;
  localparam int DEF_T_ALLRED = 1;
  localparam int DEF_T_WALK   = 10;

  function automatic light_t ns_lamp(phase_t p);
    case (p)
      NS_GREEN:  return GREEN;
      NS_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  function automatic light_t ew_lamp(phase_t p);
    case (p)
      EW_GREEN:  return GREEN;
      EW_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm.sv
// Phase controller for a two-way intersection: timed green/yellow/all-red cycle,
// pedestrian walk insertion after all-red, and an all-red emergency override.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_WALK   = DEF_T_WALK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] timer_count,
  output logic             timer_start,
  input  logic             ped_req,
  input  logic             emergency,
  output light_t           ns_light,
  output light_t           ew_light,
  output logic             walk
);

  localparam logic [WIDTH-1:0] LAST_GREEN  = WIDTH'(T_GREEN - 1);
  localparam logic [WIDTH-1:0] LAST_YELLOW = WIDTH'(T_YELLOW - 1);
  localparam logic [WIDTH-1:0] LAST_ALLRED = WIDTH'(T_ALLRED - 1);
  localparam logic [WIDTH-1:0] LAST_WALK   = WIDTH'(T_WALK - 1);

  phase_t state;
  phase_t next_state;
  logic   ped_pending;
  dir_t   next_dir;

  // Emergency wins over every timed exit; EMERG ignores the timer entirely.
  always_comb begin
    next_state = state;
    if (emergency && state != EMERG) begin
      next_state = EMERG;
    end else begin
      case (state)
        NS_GREEN:  if (timer_count == LAST_GREEN)  next_state = NS_YELLOW;
        NS_YELLOW: if (timer_count == LAST_YELLOW) next_state = ALLRED_A;
        ALLRED_A:  if (timer_count == LAST_ALLRED)
                     next_state = ped_pending ? PED_WALK : EW_GREEN;
        EW_GREEN:  if (timer_count == LAST_GREEN)  next_state = EW_YELLOW;
        EW_YELLOW: if (timer_count == LAST_YELLOW) next_state = ALLRED_B;
        ALLRED_B:  if (timer_count == LAST_ALLRED)
                     next_state = ped_pending ? PED_WALK : NS_GREEN;
        PED_WALK:  if (timer_count == LAST_WALK)
                     next_state = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
        EMERG:     if (!emergency) next_state = ALLRED_B;
        default:   next_state = NS_GREEN;
      endcase
    end
  end

  // Restart the timer in the last cycle of a phase so the new phase starts at 0.
  assign timer_start = rst_n && (next_state != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NS_GREEN;
      ped_pending <= 1'b0;
      next_dir    <= DIR_NS;
      ns_light    <= GREEN;
      ew_light    <= RED;
      walk        <= 1'b0;
    end else begin
      state    <= next_state;
      ns_light <= ns_lamp(next_state);
      ew_light <= ew_lamp(next_state);
      walk     <= (next_state == PED_WALK);

      if (next_state == PED_WALK && state != PED_WALK) begin
        ped_pending <= 1'b0;
      end else if (ped_req && state != PED_WALK) begin
        ped_pending <= 1'b1;
      end

      // Remember which green a walk phase displaced.
      if (state == ALLRED_A && next_state != ALLRED_A) begin
        next_dir <= DIR_EW;
      end else if (state == ALLRED_B && next_state != ALLRED_B) begin
        next_dir <= DIR_NS;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: a seconds timer beside the DUT and a countdown
// reference model of the phase sequence driving an expected-lamp queue.
module tb_traffic_light_fsm;

  localparam int W  = 6;
  localparam int TG = 20;
  localparam int TY = 3;
  localparam int TA = 1;
  localparam int TW = 10;

  localparam int P_NSG  = 0;
  localparam int P_NSY  = 1;
  localparam int P_ARA  = 2;
  localparam int P_EWG  = 3;
  localparam int P_EWY  = 4;
  localparam int P_ARB  = 5;
  localparam int P_WALK = 6;
  localparam int P_EMG  = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ped_req = 1'b0;
  logic         emergency = 1'b0;
  logic [W-1:0] timer_count;
  logic         timer_start;
  logic [1:0]   ns_light;
  logic [1:0]   ew_light;
  logic         walk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase;
  int m_left;
  bit m_ped;
  bit m_dir_ew;
  logic [4:0] exp_q[$];

  // ---------------- clock / reset / timer ----------------
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timer_count <= '0;
    else if (timer_start) timer_count <= '0;
    else                  timer_count <= timer_count + 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  traffic_light_fsm #(
    .WIDTH(W), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .timer_count(timer_count),
    .timer_start(timer_start),
    .ped_req(ped_req),
    .emergency(emergency),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .walk(walk)
  );

  // ---------------- reference model ----------------
  function automatic int dur(int p);
    case (p)
      P_NSG, P_EWG: return TG;
      P_NSY, P_EWY: return TY;
      P_ARA, P_ARB: return TA;
      P_WALK:       return TW;
      default:      return 1;
    endcase
  endfunction

  // {ns, ew, walk} with RED=00, YELLOW=01, GREEN=10
  function automatic logic [4:0] lamps(int p);
    case (p)
      P_NSG:   return {2'b10, 2'b00, 1'b0};
      P_NSY:   return {2'b01, 2'b00, 1'b0};
      P_EWG:   return {2'b00, 2'b10, 1'b0};
      P_EWY:   return {2'b00, 2'b01, 1'b0};
      P_WALK:  return {2'b00, 2'b00, 1'b1};
      default: return {2'b00, 2'b00, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_phase  = P_NSG;
    m_left   = TG;
    m_ped    = 1'b0;
    m_dir_ew = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit p, input bit e, output logic obs_start, output bit exp_start);
    int nxt;
    @(negedge clk);
    ped_req   = p;
    emergency = e;
    #1;
    obs_start = timer_start;
    nxt = m_phase;
    if (e && m_phase != P_EMG) nxt = P_EMG;
    else if (m_phase == P_EMG) begin
      if (!e) nxt = P_ARB;
    end else if (m_left == 1) begin
      case (m_phase)
        P_NSG:   nxt = P_NSY;
        P_NSY:   nxt = P_ARA;
        P_ARA:   nxt = m_ped ? P_WALK : P_EWG;
        P_EWG:   nxt = P_EWY;
        P_EWY:   nxt = P_ARB;
        P_ARB:   nxt = m_ped ? P_WALK : P_NSG;
        default: nxt = m_dir_ew ? P_EWG : P_NSG;
      endcase
    end
    if (nxt == P_WALK && m_phase != P_WALK) begin
      m_ped    = 1'b0;
      m_dir_ew = (m_phase == P_ARA);
    end else if (p && m_phase != P_WALK) begin
      m_ped = 1'b1;
    end
    exp_start = (nxt != m_phase);
    m_left    = exp_start ? dur(nxt) : m_left - 1;
    m_phase   = nxt;
    exp_q.push_back(lamps(m_phase));
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ped_req = 1'b0;
    emergency = 1'b0;
    release_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ns_light, ew_light, walk, timer_start} !== {2'b10, 2'b00, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got %b required %b", {ns_light, ew_light, walk, timer_start}, 6'b100000);
    else n_pass++;
    release_reset();
  endtask

  task automatic test_normal_cycle();
    logic os; bit es; logic [4:0] ex;
    int starts = 0, nsg = 0, ewg = 0, walks = 0;
    for (int i = 0; i < 96; i++) begin
      tick(1'b0, 1'b0, os, es);
      n_checks++;
      if (os !== es) $display("FAIL normal_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL normal_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      starts += (os === 1'b1);
      nsg    += (ns_light === 2'b10);
      ewg    += (ew_light === 2'b10);
      walks  += (walk === 1'b1);
    end
    n_checks++;
    if (starts != 12) $display("FAIL normal_start_count: got %0d required 12", starts); else n_pass++;
    n_checks++;
    if (nsg != 40 || ewg != 40) $display("FAIL normal_green_cycles: got ns=%0d ew=%0d required 40/40", nsg, ewg); else n_pass++;
    n_checks++;
    if (walks != 0) $display("FAIL normal_no_walk: got %0d required 0", walks); else n_pass++;
  endtask

  task automatic test_ped_ns();
    logic os; bit es; logic [4:0] ex;
    int walks = 0; bit second = 0; bit p;
    hard_reset();
    for (int i = 0; i < 66; i++) begin
      p = (i == 5);
      if (m_phase == P_WALK && !second) begin p = 1'b1; second = 1'b1; end
      tick(p, 1'b0, os, es);
      n_checks++;
      if (os !== es) $display("FAIL ped_ns_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL ped_ns_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      walks += (walk === 1'b1);
    end
    n_checks++;
    if (walks != TW) $display("FAIL ped_ns_walk_len: got %0d required %0d", walks, TW); else n_pass++;
  endtask

  task automatic test_ped_ew();
    logic os; bit es; logic [4:0] ex;
    int walks = 0, guard = 0;
    hard_reset();
    while (m_phase != P_EWG && guard < 100) begin
      tick(1'b0, 1'b0, os, es);
      void'(exp_q.pop_front());
      guard++;
    end
    n_checks++;
    if (ew_light !== 2'b10) $display("FAIL ped_ew_reach_ewg: got %b required 10", ew_light); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      tick(i == 2, 1'b0, os, es);
      n_checks++;
      if (os !== es) $display("FAIL ped_ew_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL ped_ew_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      walks += (walk === 1'b1);
    end
    n_checks++;
    if (walks != TW || ns_light !== 2'b10) $display("FAIL ped_ew_walk_then_ns: got walk=%0d ns=%b required %0d/10", walks, ns_light, TW); else n_pass++;
  endtask

  task automatic test_emergency();
    logic os; bit es; logic [4:0] ex;
    int guard = 0, nsg = 0; bit e;
    hard_reset();
    while (!(m_phase == P_NSY && m_left == 1) && guard < 100) begin
      tick(1'b0, 1'b0, os, es);
      void'(exp_q.pop_front());
      guard++;
    end
    for (int i = 0; i < 29; i++) begin
      e = (i < 7);
      tick(1'b0, e, os, es);
      n_checks++;
      if (os !== es) $display("FAIL emerg_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL emerg_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      if (i >= 8) nsg += (ns_light === 2'b10);
    end
    n_checks++;
    if (nsg != TG) $display("FAIL emerg_ns_green_after: got %0d required %0d", nsg, TG); else n_pass++;
  endtask

  task automatic test_emerg_ped();
    logic os; bit es; logic [4:0] ex;
    int walks = 0;
    hard_reset();
    for (int i = 0; i < 22; i++) begin
      tick(i == 3, i < 6, os, es);
      n_checks++;
      if (os !== es) $display("FAIL emped_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL emped_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      walks += (walk === 1'b1);
    end
    n_checks++;
    if (walks != TW || ns_light !== 2'b10) $display("FAIL emped_walk_then_ns: got walk=%0d ns=%b required %0d/10", walks, ns_light, TW); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic os; bit es; logic [4:0] ex;
    int walks = 0;
    hard_reset();
    for (int i = 0; i < 30; i++) begin
      tick(i == 26, 1'b0, os, es);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ns_light, ew_light, walk, timer_start} !== {2'b10, 2'b00, 1'b0, 1'b0})
      $display("FAIL reset_mid_outputs: got %b required %b", {ns_light, ew_light, walk, timer_start}, 6'b100000);
    else n_pass++;
    release_reset();
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b0, os, es);
      n_checks++;
      if (os !== es) $display("FAIL reset_mid_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL reset_mid_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
      walks += (walk === 1'b1);
    end
    n_checks++;
    if (walks != 0) $display("FAIL reset_mid_no_walk: got %0d required 0", walks); else n_pass++;
  endtask

  task automatic test_random();
    logic os; bit es; logic [4:0] ex;
    bit e = 0, p;
    int burst = 0;
    hard_reset();
    for (int i = 0; i < 500; i++) begin
      p = ($urandom_range(0, 11) == 0);
      if (burst > 0) burst--;
      else if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 9);
      e = (burst > 0);
      tick(p, e, os, es);
      n_checks++;
      if (os !== es) $display("FAIL random_start c%0d: got %b required %b", i, os, es); else n_pass++;
      ex = exp_q.pop_front();
      n_checks++;
      if ({ns_light, ew_light, walk} !== ex) $display("FAIL random_lamps c%0d: got %b required %b", i, {ns_light, ew_light, walk}, ex); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_ns();
    test_ped_ew();
    test_emergency();
    test_emerg_ped();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
